// File: rtl/jelly2_img_line_moment_pkg.sv
// Shared types for the line-moment collector: FSM state, per-line frame flags and
// the exit rule applied when a frame's last line is seen.
package jelly2_img_line_moment_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   typedef struct packed {
      logic first;
      logic last;
   } line_flags_t;

   function automatic state_t frame_exit_state(input logic oneshot, input logic enable);
      return (oneshot || !enable) ? ST_IDLE : ST_WAIT;
   endfunction

endpackage

// File: rtl/jelly2_img_line_moment_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered RAM read stage.
// Depth is 2**PTR_WIDTH; count reports entries written and not yet popped.
module jelly2_img_line_moment_fifo #(
   parameter int DATA_WIDTH = 34,
   parameter int PTR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [PTR_WIDTH:0]    count
);

   localparam int DEPTH = 2 ** PTR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [PTR_WIDTH-1:0]  wr_ptr_reg;
   logic [PTR_WIDTH-1:0]  rd_ptr_reg;
   logic [PTR_WIDTH-1:0]  rd_addr;
   logic [PTR_WIDTH:0]    count_reg;
   logic [PTR_WIDTH:0]    count_next;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  valid_reg;
   logic                  pop;

   assign pop     = valid_reg && m_ready;
   // Prefetch the following entry on a pop so the output register is never a cycle stale.
   assign rd_addr = rd_ptr_reg + PTR_WIDTH'(pop);

   always_comb begin
      count_next = count_reg;
      if (s_valid && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (!s_valid && pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (s_valid) begin
         mem[wr_ptr_reg] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      data_reg <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= 1'b0;
      end else begin
         if (s_valid) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
         // Only entries already in RAM at this edge can be presented next cycle.
         valid_reg <= (count_reg - (PTR_WIDTH+1)'(pop)) != '0;
      end
   end

   assign m_data  = data_reg;
   assign m_valid = valid_reg;
   assign count   = count_reg;

endmodule

// File: rtl/jelly2_img_line_moment_collector.sv
// Frame-sequenced collector of per-line {m1,m0} moments into an AXI4-Stream with frame framing.
// Optional frame counter enabled by defining JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN.
module jelly2_img_line_moment_collector
   import jelly2_img_line_moment_pkg::*;
#(
   parameter int M0_WIDTH  = 12,
   parameter int M1_WIDTH  = 20,
   parameter int PTR_WIDTH = 4
`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
   ,parameter int FRAME_WIDTH = 16
`endif
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ctl_enable,
   input  logic                         ctl_oneshot,
   output logic                         ctl_busy,
   input  logic                         stat_clear,
   output logic                         stat_overflow,
   input  logic                         s_moment_first,
   input  logic                         s_moment_last,
   input  logic [M0_WIDTH-1:0]          s_moment_m0,
   input  logic [M1_WIDTH-1:0]          s_moment_m1,
   input  logic                         s_moment_valid,
   output logic                         m_axi4s_tuser,
   output logic                         m_axi4s_tlast,
   output logic [M1_WIDTH+M0_WIDTH-1:0] m_axi4s_tdata,
   output logic                         m_axi4s_tvalid,
   input  logic                         m_axi4s_tready
`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
   ,output logic [FRAME_WIDTH-1:0]      frame_count
`endif
);

   localparam int DEPTH = 2 ** PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] FULL_SLOTS = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] ONE_SLOT   = (PTR_WIDTH+1)'(1);

   typedef struct packed {
      line_flags_t           flags;
      logic [M1_WIDTH-1:0]   m1;
      logic [M0_WIDTH-1:0]   m0;
   } line_entry_t;

   localparam int ENTRY_WIDTH = $bits(line_entry_t);

   state_t                 state_reg;
   state_t                 state_next;
   logic                   overflow_reg;
   logic                   overflow_set;
   logic                   push;
   logic                   force_last;
   logic                   take_line;
   logic [PTR_WIDTH:0]     fifo_count;
   logic [PTR_WIDTH:0]     free_slots;
   logic [ENTRY_WIDTH-1:0] fifo_rd_data;
   line_entry_t            wr_entry;
   line_entry_t            rd_entry;

   // Space is judged on the registered count; a pop in this cycle is not credited.
   assign free_slots = FULL_SLOTS - fifo_count;
   assign take_line  = s_moment_valid &&
                       ((state_reg == ST_WAIT && s_moment_first) || state_reg == ST_CAPTURE);

   always_comb begin
      state_next   = state_reg;
      push         = 1'b0;
      force_last   = 1'b0;
      overflow_set = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (ctl_enable) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT, ST_CAPTURE: begin
            if (take_line) begin
               if (free_slots == '0) begin
                  overflow_set = 1'b1;
                  state_next   = s_moment_last ? frame_exit_state(ctl_oneshot, ctl_enable) : ST_DROP;
               end else if (free_slots == ONE_SLOT && !s_moment_last) begin
                  // Last free slot: close the frame here so downstream framing stays intact.
                  push         = 1'b1;
                  force_last   = 1'b1;
                  overflow_set = 1'b1;
                  state_next   = ST_DROP;
               end else begin
                  push       = 1'b1;
                  state_next = s_moment_last ? frame_exit_state(ctl_oneshot, ctl_enable) : ST_CAPTURE;
               end
            end
         end
         ST_DROP: begin
            if (s_moment_valid && s_moment_last) begin
               state_next = frame_exit_state(ctl_oneshot, ctl_enable);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         overflow_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (overflow_set) begin
            overflow_reg <= 1'b1;
         end else if (stat_clear) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign wr_entry.flags.first = s_moment_first;
   assign wr_entry.flags.last  = s_moment_last || force_last;
   assign wr_entry.m1          = s_moment_m1;
   assign wr_entry.m0          = s_moment_m0;

   jelly2_img_line_moment_fifo #(
      .DATA_WIDTH (ENTRY_WIDTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .s_data  (wr_entry),
      .s_valid (push),
      .m_data  (fifo_rd_data),
      .m_valid (m_axi4s_tvalid),
      .m_ready (m_axi4s_tready),
      .count   (fifo_count)
   );

   assign rd_entry       = fifo_rd_data;
   assign m_axi4s_tuser  = rd_entry.flags.first;
   assign m_axi4s_tlast  = rd_entry.flags.last;
   assign m_axi4s_tdata  = {rd_entry.m1, rd_entry.m0};
   assign ctl_busy       = (state_reg != ST_IDLE);
   assign stat_overflow  = overflow_reg;

`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
   logic [FRAME_WIDTH-1:0] frame_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count_reg <= '0;
      end else if (push && wr_entry.flags.last) begin
         frame_count_reg <= frame_count_reg + 1'b1;
      end
   end

   assign frame_count = frame_count_reg;
`endif

`ifndef SYNTHESIS
   // Capturing with no free slot would mean a truncation failed to move to DROP.
   always_ff @(posedge clk) begin
      if (!reset && state_reg == ST_CAPTURE && s_moment_valid) begin
         assert (free_slots != '0);
      end
   end
`endif

endmodule

// File: tb/tb_jelly2_img_line_moment_collector.sv
// Scoreboard bench for the line-moment collector: a frame-level reference model queues
// expected beats while a separate monitor checks every AXI4-Stream handshake.
module tb_jelly2_img_line_moment_collector;

   localparam int M0_WIDTH  = 12;
   localparam int M1_WIDTH  = 20;
   localparam int PTR_WIDTH = 2;
   localparam int DEPTH     = 4;

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic                         ctl_enable = 1'b0;
   logic                         ctl_oneshot = 1'b0;
   logic                         ctl_busy;
   logic                         stat_clear = 1'b0;
   logic                         stat_overflow;
   logic                         s_first = 1'b0;
   logic                         s_last = 1'b0;
   logic [M0_WIDTH-1:0]          s_m0 = '0;
   logic [M1_WIDTH-1:0]          s_m1 = '0;
   logic                         s_valid = 1'b0;
   logic                         tuser;
   logic                         tlast;
   logic [M1_WIDTH+M0_WIDTH-1:0] tdata;
   logic                         tvalid;
   logic                         tready = 1'b0;
`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
   logic [15:0]                  frame_count;
`endif

   always #5 clk = ~clk;

   jelly2_img_line_moment_collector #(
      .M0_WIDTH  (M0_WIDTH),
      .M1_WIDTH  (M1_WIDTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ctl_enable     (ctl_enable),
      .ctl_oneshot    (ctl_oneshot),
      .ctl_busy       (ctl_busy),
      .stat_clear     (stat_clear),
      .stat_overflow  (stat_overflow),
      .s_moment_first (s_first),
      .s_moment_last  (s_last),
      .s_moment_m0    (s_m0),
      .s_moment_m1    (s_m1),
      .s_moment_valid (s_valid),
      .m_axi4s_tuser  (tuser),
      .m_axi4s_tlast  (tlast),
      .m_axi4s_tdata  (tdata),
      .m_axi4s_tvalid (tvalid),
      .m_axi4s_tready (tready)
`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
      ,.frame_count   (frame_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic                first;
      logic                last;
      logic [M1_WIDTH-1:0] m1;
      logic [M0_WIDTH-1:0] m0;
   } beat_t;

   beat_t exp_q[$];

   // Reference model: frame phase as seen by software, evaluated at the negedge for the next edge.
   typedef enum {M_IDLE, M_ARMED, M_IN_FRAME, M_SKIP} mode_t;
   mode_t       m_mode = M_IDLE;
   int          m_occ  = 0;
   logic        m_ovf  = 1'b0;
   logic [15:0] m_fcnt = '0;
   logic        m_pop, m_part, m_trunc, m_ovf_set;
   int          m_push, m_free;
   beat_t       m_beat;

   always @(negedge clk) begin
      check("ctl_busy", ctl_busy, m_mode != M_IDLE);
      check("stat_overflow", stat_overflow, m_ovf);
`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
      check("frame_count", frame_count, m_fcnt);
`endif
      if (reset) begin
         exp_q.delete();
         m_mode = M_IDLE;
         m_occ  = 0;
         m_ovf  = 1'b0;
         m_fcnt = '0;
      end else begin
         m_pop     = tvalid && tready;
         m_push    = 0;
         m_ovf_set = 1'b0;
         m_free    = DEPTH - m_occ;
         if (m_mode == M_IDLE) begin
            if (ctl_enable) m_mode = M_ARMED;
         end else if (s_valid) begin
            m_part = (m_mode == M_IN_FRAME) || (m_mode == M_SKIP) || (m_mode == M_ARMED && s_first);
            if (m_part && m_mode != M_SKIP) begin
               if (m_free == 0) begin
                  m_ovf_set = 1'b1;
                  m_mode    = M_SKIP;
               end else begin
                  m_trunc      = (m_free == 1) && !s_last;
                  m_beat.first = s_first;
                  m_beat.last  = s_last || m_trunc;
                  m_beat.m1    = s_m1;
                  m_beat.m0    = s_m0;
                  exp_q.push_back(m_beat);
                  m_push = 1;
                  if (m_beat.last) m_fcnt = m_fcnt + 16'd1;
                  if (m_trunc) begin
                     m_ovf_set = 1'b1;
                     m_mode    = M_SKIP;
                  end else begin
                     m_mode = M_IN_FRAME;
                  end
               end
            end
            if (m_part && s_last) m_mode = (ctl_oneshot || !ctl_enable) ? M_IDLE : M_ARMED;
         end
         if (m_ovf_set) m_ovf = 1'b1;
         else if (stat_clear) m_ovf = 1'b0;
         m_occ = m_occ + m_push - int'(m_pop);
      end
   end

   // Monitor: pops on each handshake and checks hold stability while stalled.
   beat_t                        mon_beat;
   logic                         hold_pend = 1'b0;
   logic [M1_WIDTH+M0_WIDTH+1:0] hold_val;

   always @(negedge clk) begin
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", tvalid, 1'b1);
            check("hold_payload", {tuser, tlast, tdata}, hold_val);
         end
         hold_pend = tvalid && !tready;
         hold_val  = {tuser, tlast, tdata};
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {tuser, tlast, tdata}, '0);
            end else begin
               mon_beat = exp_q.pop_front();
               check("tdata", tdata, {mon_beat.m1, mon_beat.m0});
               check("tuser", tuser, mon_beat.first);
               check("tlast", tlast, mon_beat.last);
            end
         end
      end
   end

   logic rand_ready = 1'b0;

   always begin
      @(posedge clk);
      #1;
      if (rand_ready) tready = ($urandom_range(0, 3) != 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_line(input logic first, input logic last, input logic [M0_WIDTH-1:0] m0v);
      s_valid = 1'b1;
      s_first = first;
      s_last  = last;
      s_m0    = m0v;
      s_m1    = M1_WIDTH'($urandom());
      tick();
      s_valid = 1'b0;
      s_first = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         send_line(i == 0, i == n - 1, M0_WIDTH'($urandom()));
         repeat (gap) tick();
      end
   endtask

   task automatic drain();
      int cyc;
      tready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         tick();
         cyc++;
      end
      check("drain_remaining", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("reset_tvalid", tvalid, 1'b0);
      check("reset_busy", ctl_busy, 1'b0);

      // 4-line frame, m0 = 1..4, sink always ready
      ctl_enable = 1'b1;
      tready     = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < 4; i++) begin
         send_line(i == 0, i == 3, M0_WIDTH'(i + 1));
         if (i == 1) check("t1_busy", ctl_busy, 1'b1);
      end
      drain();

      // oneshot: software drops enable once armed; back-to-back second frame is ignored
      ctl_oneshot = 1'b1;
      repeat (2) tick();
      send_line(1'b1, 1'b0, 12'h011);
      ctl_enable = 1'b0;
      send_line(1'b0, 1'b0, 12'h012);
      send_line(1'b0, 1'b1, 12'h013);
      send_frame(3, 0);
      check("t2_busy", ctl_busy, 1'b0);
      drain();
      ctl_oneshot = 1'b0;

      // stalled sink, 6-line frame into 4 slots: truncation at line 4
      ctl_enable = 1'b1;
      tready     = 1'b0;
      repeat (2) tick();
      send_frame(6, 0);
      repeat (2) tick();
      check("t3_overflow", stat_overflow, 1'b1);
      check("t3_tvalid", tvalid, 1'b1);
      drain();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      tick();
      check("t3_cleared", stat_overflow, 1'b0);

      // full FIFO while waiting: next frame is lost entirely
      tready = 1'b0;
      send_frame(4, 0);
      tick();
      check("t4_no_overflow", stat_overflow, 1'b0);
      send_frame(3, 1);
      tick();
      check("t4_overflow", stat_overflow, 1'b1);
      drain();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;

      // enable dropped mid-frame: frame completes, then idle; re-arm mid-frame waits for first
      tready = 1'b1;
      tick();
      send_line(1'b1, 1'b0, 12'h051);
      send_line(1'b0, 1'b0, 12'h052);
      ctl_enable = 1'b0;
      send_line(1'b0, 1'b0, 12'h053);
      send_line(1'b0, 1'b1, 12'h054);
      tick();
      check("t5_idle", ctl_busy, 1'b0);
      send_line(1'b1, 1'b0, 12'h061);
      ctl_enable = 1'b1;
      tick();
      send_line(1'b0, 1'b0, 12'h062);
      send_line(1'b0, 1'b1, 12'h063);
      send_frame(2, 0);
      send_frame(1, 1);
      drain();

      // reset with three entries queued
      tready = 1'b0;
      send_frame(3, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #3;
      check("t6_tvalid", tvalid, 1'b0);
      check("t6_overflow", stat_overflow, 1'b0);
      check("t6_busy", ctl_busy, 1'b0);
`ifdef JELLY2_LINE_MOMENT_COLLECTOR_FCNT_EN
      check("t6_frame_count", frame_count, 16'd0);
`endif
      tick();

      // randomized frames, sink throttling and control changes
      rand_ready = 1'b1;
      for (int f = 0; f < 80; f++) begin
         if ($urandom_range(0, 9) == 0) ctl_oneshot = ~ctl_oneshot;
         ctl_enable = ($urandom_range(0, 9) != 0);
         stat_clear = ($urandom_range(0, 7) == 0);
         send_frame($urandom_range(1, 6), $urandom_range(0, 2));
         stat_clear = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      rand_ready = 1'b0;
      tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
